// File: rtl/matrix_rx_loader.sv
`default_nettype none
// ============================================================================
//  Module   : matrix_rx_loader
//  Purpose  : Assembles UART RX bytes (MSB-first) into N x N matrix elements
//             and writes them row-major into the A then B operand buffers.
//             Pulses load_done when both are full and frame_err when a
//             stalled frame is aborted by the inter-byte timeout.
//  Revision : 1.0  initial release
// ============================================================================
module matrix_rx_loader #(
    parameter int N           = 2,
    parameter int ELEM_W      = 8,
    parameter int ADDR_W      = 4,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              load_en,
    output logic              wr_en_a,
    output logic              wr_en_b,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ELEM_W-1:0] wr_data,
    output logic              load_done,
    output logic              frame_err,
    output logic              busy
);

    localparam int BYTES = ELEM_W / 8;
    localparam int NN    = N * N;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int ICW   = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD_A = 2'd1,
        ST_LOAD_B = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [BCW-1:0]    byte_cnt_q;
    logic [ADDR_W-1:0] elem_cnt_q;
    logic [ICW-1:0]    idle_cnt_q;

    logic              wr_en_a_q;
    logic              wr_en_b_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [ELEM_W-1:0] wr_data_q;
    logic              load_done_q;
    logic              frame_err_q;
    logic              busy_q;

    logic              w_in_load;
    logic              w_accept;
    logic              w_byte_last;
    logic              w_elem_last;
    logic              w_timeout;
    logic [ELEM_W-1:0] w_asm;

    assign w_in_load   = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);
    // A byte is taken in IDLE only when a new frame is allowed; inside a frame always.
    assign w_accept    = rx_valid && (((state_q == ST_IDLE) && load_en) || w_in_load);
    assign w_byte_last = (byte_cnt_q == BCW'(BYTES - 1));
    assign w_elem_last = (elem_cnt_q == ADDR_W'(NN - 1));
    // A byte arriving in the expiry cycle cancels the timeout.
    assign w_timeout   = w_in_load && !rx_valid && (idle_cnt_q == ICW'(TIMEOUT_CYC - 1));

    generate
        if (BYTES == 1) begin : g_single_byte
            assign w_asm = rx_data;
        end else begin : g_multi_byte
            // Only the lower ELEM_W-8 bits of the shift register are ever
            // needed: the top byte of a completed element is shifted out.
            logic [ELEM_W-9:0] shreg_q;

            // Accumulate earlier bytes of the element being assembled.
            always_ff @(posedge clk) begin
                if (rst) begin
                    shreg_q <= '0;
                end else if (w_accept) begin
                    shreg_q <= w_asm[ELEM_W-9:0];
                end
            end

            assign w_asm = {shreg_q, rx_data};
        end
    endgenerate

    // Next-state decode: the buffer switch happens on the last element's write.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_byte_last && w_elem_last) begin
                        state_d = ST_LOAD_B;
                    end else begin
                        state_d = ST_LOAD_A;
                    end
                end
            end
            ST_LOAD_A: begin
                if (w_timeout) begin
                    state_d = ST_IDLE;
                end else if (w_accept && w_byte_last && w_elem_last) begin
                    state_d = ST_LOAD_B;
                end
            end
            ST_LOAD_B: begin
                if (w_timeout) begin
                    state_d = ST_IDLE;
                end else if (w_accept && w_byte_last && w_elem_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            byte_cnt_q  <= '0;
            elem_cnt_q  <= '0;
            idle_cnt_q  <= '0;
            wr_en_a_q   <= 1'b0;
            wr_en_b_q   <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            load_done_q <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= (state_d == ST_LOAD_A) || (state_d == ST_LOAD_B);
            wr_en_a_q   <= 1'b0;
            wr_en_b_q   <= 1'b0;
            load_done_q <= (state_q == ST_DONE);
            frame_err_q <= w_timeout;

            if (w_timeout) begin
                // Abort: the partial element is simply forgotten.
                byte_cnt_q <= '0;
                elem_cnt_q <= '0;
                idle_cnt_q <= '0;
            end else if (w_accept) begin
                idle_cnt_q <= '0;
                if (w_byte_last) begin
                    byte_cnt_q <= '0;
                    wr_addr_q  <= elem_cnt_q;
                    wr_data_q  <= w_asm;
                    wr_en_a_q  <= (state_q != ST_LOAD_B);
                    wr_en_b_q  <= (state_q == ST_LOAD_B);
                    elem_cnt_q <= w_elem_last ? '0 : (elem_cnt_q + ADDR_W'(1));
                end else begin
                    byte_cnt_q <= byte_cnt_q + BCW'(1);
                end
            end else if (w_in_load) begin
                idle_cnt_q <= idle_cnt_q + ICW'(1);
            end
        end
    end

    assign wr_en_a   = wr_en_a_q;
    assign wr_en_b   = wr_en_b_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign load_done = load_done_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_rx_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_matrix_rx_loader
//  Purpose  : Self-checking bench for matrix_rx_loader. Two instances
//             (8-bit and 16-bit elements, short timeout) share one stimulus
//             stream and are each checked every cycle against a frame-level
//             reference model, plus a vector table and directed sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_matrix_rx_loader;

    localparam int NN = 4;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       load_en;

    logic       a_wa, a_wb, a_ld, a_fe, a_busy;
    logic [3:0] a_addr;
    logic [7:0] a_data;
    logic       b_wa, b_wb, b_ld, b_fe, b_busy;
    logic [3:0] b_addr;
    logic [15:0] b_data;

    matrix_rx_loader #(.N(2), .ELEM_W(8), .ADDR_W(4), .TIMEOUT_CYC(TO)) dut_a (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .load_en(load_en),
        .wr_en_a(a_wa), .wr_en_b(a_wb), .wr_addr(a_addr), .wr_data(a_data),
        .load_done(a_ld), .frame_err(a_fe), .busy(a_busy)
    );

    matrix_rx_loader #(.N(2), .ELEM_W(16), .ADDR_W(4), .TIMEOUT_CYC(TO)) dut_b (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .load_en(load_en),
        .wr_en_a(b_wa), .wr_en_b(b_wb), .wr_addr(b_addr), .wr_data(b_data),
        .load_done(b_ld), .frame_err(b_fe), .busy(b_busy)
    );

    always #5 clk = ~clk;

    // Frame-level reference: bytes of the current frame are counted, and the
    // element index / buffer / address are derived arithmetically from it.
    typedef struct {
        logic        active;
        logic        donep;
        int          nb;
        int          since;
        logic [31:0] val;
        logic        wa, wb, ld, fe, busy;
        logic [3:0]  addr;
        logic [31:0] data;
    } mdl_t;

    typedef struct {
        bit         r, v, en;
        logic [7:0] d;
        bit         wa, wb, ld, busy;
        logic [3:0] addr;
        logic [7:0] data;
    } vec_t;

    mdl_t m8, m16;
    int ncmp = 0, nerr = 0;
    int ld_a = 0, ld_b = 0, fe_a = 0, fe_b = 0, wr_a = 0;

    function automatic mdl_t m_accept(mdl_t m, int bytes, logic [7:0] d);
        int e;
        m.since = 0;
        m.val   = ((m.val << 8) | {24'h0, d}) & ((bytes == 1) ? 32'hFF : 32'hFFFF);
        m.nb    = m.nb + 1;
        if (m.nb % bytes == 0) begin
            e      = m.nb / bytes - 1;
            m.addr = 4'(e % NN);
            m.data = m.val;
            if (e < NN) m.wa = 1'b1;
            else        m.wb = 1'b1;
            if (e == 2 * NN - 1) begin
                m.active = 1'b0;
                m.donep  = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic mdl_t mstep(mdl_t m, int bytes, bit r, bit v, logic [7:0] d, bit en);
        m.wa = 1'b0; m.wb = 1'b0; m.ld = 1'b0; m.fe = 1'b0;
        if (r) begin
            m = '{default: 0};
        end else if (m.donep) begin
            m.ld    = 1'b1;
            m.donep = 1'b0;
        end else if (!m.active) begin
            if (v && en) begin
                m.active = 1'b1;
                m.nb     = 0;
                m.val    = 32'h0;
                m        = m_accept(m, bytes, d);
            end
        end else if (v) begin
            m = m_accept(m, bytes, d);
        end else if (m.since == TO - 1) begin
            m.fe     = 1'b1;
            m.active = 1'b0;
        end else begin
            m.since = m.since + 1;
        end
        m.busy = m.active;
        return m;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, compare both instances.
    task automatic step(bit r, bit v, logic [7:0] d, bit en);
        rst = r; rx_valid = v; rx_data = d; load_en = en;
        @(posedge clk);
        m8  = mstep(m8, 1, r, v, d, en);
        m16 = mstep(m16, 2, r, v, d, en);
        #1;
        chk("model_e8",  {a_wa, a_wb, a_ld, a_fe, a_busy, a_addr, 24'h0, a_data},
                         {m8.wa, m8.wb, m8.ld, m8.fe, m8.busy, m8.addr, m8.data});
        chk("model_e16", {b_wa, b_wb, b_ld, b_fe, b_busy, b_addr, 16'h0, b_data},
                         {m16.wa, m16.wb, m16.ld, m16.fe, m16.busy, m16.addr, m16.data});
        ld_a += int'(a_ld); ld_b += int'(b_ld);
        fe_a += int'(a_fe); fe_b += int'(b_fe);
        wr_a += int'(a_wa | a_wb);
    endtask

    task automatic clr_counts();
        ld_a = 0; ld_b = 0; fe_a = 0; fe_b = 0; wr_a = 0;
    endtask

    vec_t tbl[12];

    initial begin
        int fe_n, fe_at;
        int mode;
        bit rv;
        m8  = '{default: 0};
        m16 = '{default: 0};
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; load_en = 1'b0;

        // ---- vector table: reset, back-to-back frame, DONE, dropped byte ----
        tbl[0] = '{r: 1, v: 0, en: 1, d: 8'h00, wa: 0, wb: 0, ld: 0, busy: 0, addr: 4'd0, data: 8'h00};
        for (int i = 1; i <= 8; i++) begin
            tbl[i] = '{r: 0, v: 1, en: 1, d: 8'(i), wa: (i <= 4), wb: (i > 4), ld: 0,
                       busy: (i < 8), addr: 4'((i - 1) % 4), data: 8'(i)};
        end
        tbl[9]  = '{r: 0, v: 0, en: 1, d: 8'h00, wa: 0, wb: 0, ld: 1, busy: 0, addr: 4'd3, data: 8'h08};
        tbl[10] = '{r: 0, v: 0, en: 1, d: 8'h00, wa: 0, wb: 0, ld: 0, busy: 0, addr: 4'd3, data: 8'h08};
        tbl[11] = '{r: 0, v: 1, en: 0, d: 8'hAA, wa: 0, wb: 0, ld: 0, busy: 0, addr: 4'd3, data: 8'h08};
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].en);
            chk($sformatf("tbl[%0d]", i), {a_wa, a_wb, a_addr, a_data, a_ld, a_busy},
                {tbl[i].wa, tbl[i].wb, tbl[i].addr, tbl[i].data, tbl[i].ld, tbl[i].busy});
        end

        // ---- frame with 3-cycle gaps ----
        step(1, 0, 0, 1);
        clr_counts();
        for (int i = 1; i <= 8; i++) begin
            step(0, 1, 8'(i), 1);
            repeat (3) step(0, 0, 0, 1);
        end
        chk("gap_writes", wr_a, 8);
        chk("gap_load_done", ld_a, 1);
        chk("gap_busy_end", a_busy, 0);

        // ---- 16-bit element assembly ----
        step(1, 0, 0, 1);
        step(0, 1, 8'h12, 1);
        chk("e16_no_write_yet", {b_wa, b_wb}, 2'b00);
        step(0, 1, 8'h34, 1);
        chk("e16_word", {b_wa, b_addr, b_data}, {1'b1, 4'd0, 16'h1234});

        // ---- timeout after 5 bytes ----
        step(1, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 8'(8'h40 + i), 1);
        fe_n = 0; fe_at = 0;
        for (int k = 1; k <= 12; k++) begin
            step(0, 0, 0, 1);
            if (a_fe) begin fe_n++; fe_at = k; end
        end
        chk("to_pulses", fe_n, 1);
        chk("to_cycle", fe_at, TO);
        chk("to_busy", a_busy, 0);
        step(0, 1, 8'h61, 1);
        chk("to_restart_a0", {a_wa, a_addr, a_data}, {1'b1, 4'd0, 8'h61});
        for (int i = 1; i < 8; i++) step(0, 1, 8'(8'h61 + i), 1);
        repeat (3) step(0, 0, 0, 1);

        // ---- byte exactly in the expiry cycle ----
        step(1, 0, 0, 1);
        clr_counts();
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 8'(8'h80 + i), 1);
            if (i < 15) repeat (TO - 1) step(0, 0, 0, 1);
        end
        repeat (3) step(0, 0, 0, 1);
        chk("exp_no_err", fe_a + fe_b, 0);
        chk("exp_done_e8", ld_a, 2);
        chk("exp_done_e16", ld_b, 1);

        // ---- load_en low in IDLE ----
        step(1, 0, 0, 1);
        clr_counts();
        for (int i = 0; i < 3; i++) step(0, 1, 8'(8'hC0 + i), 0);
        chk("en0_no_writes", wr_a, 0);
        chk("en0_busy", a_busy, 0);
        step(0, 1, 8'h55, 1);
        chk("en1_first_a0", {a_wa, a_addr, a_data, a_busy}, {1'b1, 4'd0, 8'h55, 1'b1});

        // ---- reset mid-frame ----
        step(1, 0, 0, 1);
        clr_counts();
        for (int i = 0; i < 6; i++) step(0, 1, 8'(8'hD0 + i), 1);
        step(1, 0, 0, 1);
        chk("rst_outputs", {a_wa, a_wb, a_addr, a_data, a_ld, a_fe, a_busy}, 19'h0);
        for (int i = 0; i < 8; i++) step(0, 1, 8'(8'hE0 + i), 1);
        repeat (3) step(0, 0, 0, 1);
        chk("rst_then_done", ld_a, 1);

        // ---- randomized traffic ----
        mode = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 50 == 0) mode = int'($urandom_range(0, 2));
            case (mode)
                0:       rv = ($urandom_range(0, 1) == 1);
                1:       rv = ($urandom_range(0, 11) == 0);
                default: rv = 1'b1;
            endcase
            step(($urandom_range(0, 399) == 0), rv, 8'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
`default_nettype wire
